// File: rtl/pe_multimode.sv
// pe_multimode: systolic PE running weight-stationary (WS) or output-stationary (OS) with a south drain chain.
// Optional macro PE_SATURATE_EN: saturating ACC_W adds and a sticky overflow flag (otherwise wrap, flag stays 0).
module pe_multimode #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pe_mode_in,
  input  logic [DATA_W-1:0] pe_input_in,
  input  logic              pe_valid_in,
  input  logic              pe_switch_in,
  input  logic [DATA_W-1:0] pe_weight_in,
  input  logic              pe_valid_w_in,
  input  logic [ACC_W-1:0]  pe_psum_in,
  input  logic              pe_psum_valid_in,
  input  logic              pe_drain_in,
  output logic [DATA_W-1:0] pe_input_out,
  output logic              pe_valid_out,
  output logic              pe_switch_out,
  output logic [DATA_W-1:0] pe_weight_out,
  output logic              pe_valid_w_out,
  output logic [ACC_W-1:0]  pe_psum_out,
  output logic              pe_psum_valid_out,
  output logic              pe_drain_out,
  output logic              pe_err_out,
  output logic              pe_ovf_out
);

  localparam int PW = 2 * DATA_W;

  // ST_WS: psum flows south | ST_OS_ACC: accumulate locally | ST_OS_DRAIN: forwarding a drain wave
  typedef enum logic [1:0] {
    ST_WS       = 2'd0,
    ST_OS_ACC   = 2'd1,
    ST_OS_DRAIN = 2'd2
  } state_t;

  state_t                   r_state, w_state_nxt;
  logic signed [DATA_W-1:0] r_shadow, r_active, w_shadow_nxt, w_active_nxt;
  logic signed [ACC_W-1:0]  r_acc, w_acc_nxt, r_psum, w_psum_nxt;
  logic                     r_psum_v, w_psum_v_nxt;
  logic                     r_err, w_err_set, r_ovf, w_ovf_set;
  logic [DATA_W-1:0]        r_input_out, r_weight_out;
  logic                     r_valid_out, r_switch_out, r_valid_w_out, r_drain_out;

  logic signed [PW-1:0]     w_prod_ws, w_prod_os;
  logic signed [ACC_W-1:0]  w_prod_ws_ext, w_prod_os_ext;
  logic [ACC_W:0]           w_ws_sum, w_os_sum;
  logic                     w_mac;

  // Returns {overflow_event, sum}; overflow is only reported when saturating.
  function automatic logic [ACC_W:0] f_add(input logic signed [ACC_W-1:0] a,
                                           input logic signed [ACC_W-1:0] b);
    logic signed [ACC_W-1:0] s;
    s = a + b;
`ifdef PE_SATURATE_EN
    if ((a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1])) begin
      return {1'b1, a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}}};
    end
    return {1'b0, s};
`else
    return {1'b0, s};
`endif
  endfunction

  assign w_prod_ws     = PW'($signed(pe_input_in)) * PW'(r_active);
  assign w_prod_os     = PW'($signed(pe_input_in)) * PW'($signed(pe_weight_in));
  assign w_prod_ws_ext = ACC_W'(w_prod_ws);
  assign w_prod_os_ext = ACC_W'(w_prod_os);
  assign w_ws_sum      = f_add($signed(pe_psum_in), w_prod_ws_ext);
  assign w_os_sum      = f_add(r_acc, w_prod_os_ext);
  assign w_mac         = pe_valid_in && pe_valid_w_in;

  always_comb begin
    w_state_nxt  = r_state;
    w_acc_nxt    = r_acc;
    w_shadow_nxt = r_shadow;
    w_active_nxt = r_active;
    w_psum_nxt   = '0;
    w_psum_v_nxt = 1'b0;
    w_err_set    = 1'b0;
    w_ovf_set    = 1'b0;
    case (r_state)
      ST_WS: begin
        if (pe_mode_in) begin
          w_state_nxt = ST_OS_ACC;
          w_acc_nxt   = '0;
        end else begin
          if (pe_valid_w_in) w_shadow_nxt = pe_weight_in;
          if (pe_switch_in)  w_active_nxt = r_shadow;
          if (pe_valid_in) begin
            w_psum_nxt   = w_ws_sum[ACC_W-1:0];
            w_psum_v_nxt = 1'b1;
            w_ovf_set    = w_ws_sum[ACC_W];
          end
        end
      end
      ST_OS_ACC: begin
        if (!pe_mode_in) begin
          w_state_nxt = ST_WS;
          w_acc_nxt   = '0;
        end else if (pe_drain_in) begin
          // A colliding upstream psum is dropped in favour of our own result.
          w_psum_nxt   = w_mac ? w_os_sum[ACC_W-1:0] : r_acc;
          w_ovf_set    = w_mac && w_os_sum[ACC_W];
          w_psum_v_nxt = 1'b1;
          w_acc_nxt    = '0;
          w_err_set    = pe_psum_valid_in;
          w_state_nxt  = ST_OS_DRAIN;
        end else begin
          if (w_mac) begin
            w_acc_nxt = w_os_sum[ACC_W-1:0];
            w_ovf_set = w_os_sum[ACC_W];
          end
          w_psum_nxt   = pe_psum_valid_in ? $signed(pe_psum_in) : '0;
          w_psum_v_nxt = pe_psum_valid_in;
        end
      end
      ST_OS_DRAIN: begin
        if (w_mac) begin
          w_acc_nxt = w_os_sum[ACC_W-1:0];
          w_ovf_set = w_os_sum[ACC_W];
        end
        w_psum_nxt   = pe_psum_valid_in ? $signed(pe_psum_in) : '0;
        w_psum_v_nxt = pe_psum_valid_in;
        if (!pe_psum_valid_in) w_state_nxt = ST_OS_ACC;
      end
      default: w_state_nxt = ST_WS;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_WS;
      r_acc         <= '0;
      r_shadow      <= '0;
      r_active      <= '0;
      r_psum        <= '0;
      r_psum_v      <= 1'b0;
      r_err         <= 1'b0;
      r_ovf         <= 1'b0;
      r_input_out   <= '0;
      r_valid_out   <= 1'b0;
      r_switch_out  <= 1'b0;
      r_weight_out  <= '0;
      r_valid_w_out <= 1'b0;
      r_drain_out   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_acc         <= w_acc_nxt;
      r_shadow      <= w_shadow_nxt;
      r_active      <= w_active_nxt;
      r_psum        <= w_psum_nxt;
      r_psum_v      <= w_psum_v_nxt;
      r_err         <= r_err | w_err_set;
      r_ovf         <= r_ovf | w_ovf_set;
      r_input_out   <= pe_valid_in ? pe_input_in : '0;
      r_valid_out   <= pe_valid_in;
      r_switch_out  <= pe_switch_in;
      if (pe_valid_w_in) r_weight_out <= pe_weight_in;
      r_valid_w_out <= pe_valid_w_in;
      r_drain_out   <= pe_drain_in;
    end
  end

  assign pe_input_out      = r_input_out;
  assign pe_valid_out      = r_valid_out;
  assign pe_switch_out     = r_switch_out;
  assign pe_weight_out     = r_weight_out;
  assign pe_valid_w_out    = r_valid_w_out;
  assign pe_psum_out       = r_psum;
  assign pe_psum_valid_out = r_psum_v;
  assign pe_drain_out      = r_drain_out;
  assign pe_err_out        = r_err;
  assign pe_ovf_out        = r_ovf;

endmodule

// File: tb/tb_pe_multimode.sv
// Bench for pe_multimode: arithmetic reference model checked every cycle plus directed literal checks.
module tb_pe_multimode;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;
  localparam longint MAXV = (longint'(1) << (ACC_W - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (ACC_W - 1));

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              pe_mode_in = 1'b0;
  logic [DATA_W-1:0] pe_input_in = '0;
  logic              pe_valid_in = 1'b0;
  logic              pe_switch_in = 1'b0;
  logic [DATA_W-1:0] pe_weight_in = '0;
  logic              pe_valid_w_in = 1'b0;
  logic [ACC_W-1:0]  pe_psum_in = '0;
  logic              pe_psum_valid_in = 1'b0;
  logic              pe_drain_in = 1'b0;
  logic [DATA_W-1:0] pe_input_out;
  logic              pe_valid_out;
  logic              pe_switch_out;
  logic [DATA_W-1:0] pe_weight_out;
  logic              pe_valid_w_out;
  logic [ACC_W-1:0]  pe_psum_out;
  logic              pe_psum_valid_out;
  logic              pe_drain_out;
  logic              pe_err_out;
  logic              pe_ovf_out;

  pe_multimode #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .pe_mode_in(pe_mode_in),
    .pe_input_in(pe_input_in), .pe_valid_in(pe_valid_in), .pe_switch_in(pe_switch_in),
    .pe_weight_in(pe_weight_in), .pe_valid_w_in(pe_valid_w_in),
    .pe_psum_in(pe_psum_in), .pe_psum_valid_in(pe_psum_valid_in), .pe_drain_in(pe_drain_in),
    .pe_input_out(pe_input_out), .pe_valid_out(pe_valid_out), .pe_switch_out(pe_switch_out),
    .pe_weight_out(pe_weight_out), .pe_valid_w_out(pe_valid_w_out),
    .pe_psum_out(pe_psum_out), .pe_psum_valid_out(pe_psum_valid_out),
    .pe_drain_out(pe_drain_out), .pe_err_out(pe_err_out), .pe_ovf_out(pe_ovf_out)
  );

  initial forever #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic longint sd(input logic [DATA_W-1:0] v);
    logic signed [DATA_W-1:0] t;
    t = v;
    return longint'(t);
  endfunction

  function automatic longint sa(input logic [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] t;
    t = v;
    return longint'(t);
  endfunction

  function automatic longint wrapv(input longint x);
    logic signed [ACC_W-1:0] t;
    t = x[ACC_W-1:0];
    return longint'(t);
  endfunction

  function automatic longint add_m(input longint a, input longint b, output bit ov);
    longint s;
    s  = a + b;
    ov = 1'b0;
    if (s > MAXV || s < MINV) begin
`ifdef PE_SATURATE_EN
      ov = 1'b1;
      s  = (s > MAXV) ? MAXV : MINV;
`else
      s  = wrapv(s);
`endif
    end
    return s;
  endfunction

  // Reference model: mode 0 = WS, 1 = OS accumulating, 2 = OS draining.
  int     m_st;
  longint m_acc, m_shadow, m_active;
  longint e_input, e_weight, e_psum;
  bit     e_valid, e_switch, e_valid_w, e_drain, e_pv, e_err, e_ovf;

  task automatic model_step();
    longint p_ws, p_os, s;
    bit     ov, mac;
    if (rst) begin
      m_st = 0; m_acc = 0; m_shadow = 0; m_active = 0;
      e_input = 0; e_weight = 0; e_psum = 0;
      e_valid = 0; e_switch = 0; e_valid_w = 0; e_drain = 0; e_pv = 0; e_err = 0; e_ovf = 0;
      return;
    end
    p_ws = sd(pe_input_in) * m_active;
    p_os = sd(pe_input_in) * sd(pe_weight_in);
    mac  = pe_valid_in && pe_valid_w_in;
    e_input   = pe_valid_in ? sd(pe_input_in) : 0;
    e_valid   = pe_valid_in;
    e_switch  = pe_switch_in;
    e_valid_w = pe_valid_w_in;
    e_drain   = pe_drain_in;
    if (pe_valid_w_in) e_weight = sd(pe_weight_in);
    if (m_st != 2 && (pe_mode_in == 1'b1) != (m_st == 1)) begin
      m_st = pe_mode_in ? 1 : 0;
      m_acc = 0; e_psum = 0; e_pv = 0;
    end else if (m_st == 0) begin
      e_pv = pe_valid_in;
      e_psum = 0;
      if (pe_valid_in) begin
        e_psum = add_m(sa(pe_psum_in), p_ws, ov);
        e_ovf |= ov;
      end
      if (pe_switch_in) m_active = m_shadow;
      if (pe_valid_w_in) m_shadow = sd(pe_weight_in);
    end else if (m_st == 1 && pe_drain_in) begin
      s = m_acc;
      if (mac) begin s = add_m(m_acc, p_os, ov); e_ovf |= ov; end
      e_psum = s; e_pv = 1; m_acc = 0; m_st = 2;
      if (pe_psum_valid_in) e_err = 1;
    end else begin
      if (mac) begin m_acc = add_m(m_acc, p_os, ov); e_ovf |= ov; end
      e_psum = pe_psum_valid_in ? sa(pe_psum_in) : 0;
      e_pv   = pe_psum_valid_in;
      if (m_st == 2 && !pe_psum_valid_in) m_st = 1;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("input_out",   sd(pe_input_out),  e_input);
      chk("valid_out",   pe_valid_out,      e_valid);
      chk("switch_out",  pe_switch_out,     e_switch);
      chk("weight_out",  sd(pe_weight_out), e_weight);
      chk("valid_w_out", pe_valid_w_out,    e_valid_w);
      chk("drain_out",   pe_drain_out,      e_drain);
      chk("psum_out",    sa(pe_psum_out),   e_psum);
      chk("psum_vout",   pe_psum_valid_out, e_pv);
      chk("err_out",     pe_err_out,        e_err);
      chk("ovf_out",     pe_ovf_out,        e_ovf);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    pe_input_in = '0; pe_valid_in = 1'b0; pe_switch_in = 1'b0;
    pe_weight_in = '0; pe_valid_w_in = 1'b0;
    pe_psum_in = '0; pe_psum_valid_in = 1'b0; pe_drain_in = 1'b0;
  endtask

  task automatic mac(input int a, input int b);
    pe_input_in = DATA_W'(a); pe_valid_in = 1'b1;
    pe_weight_in = DATA_W'(b); pe_valid_w_in = 1'b1;
  endtask

  int os_a [4] = '{2, -1, 4, 0};
  int os_b [4] = '{3, 7, 4, 9};
  int ov_b [4] = '{127, 127, 4, 127};

  initial begin
    clr();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_psum", sa(pe_psum_out), 0);
    chk("rst_pv", pe_psum_valid_out, 0);
    chk("rst_err", pe_err_out, 0);
    rst = 1'b0;

    // WS basic: w=3, switch, -4*3 + 10
    clr(); pe_weight_in = 8'd3; pe_valid_w_in = 1'b1; cyc();
    chk("ws_wfwd", sd(pe_weight_out), 3);
    clr(); pe_switch_in = 1'b1; cyc();
    clr(); pe_input_in = DATA_W'(-4); pe_valid_in = 1'b1; pe_psum_in = 16'd10; pe_psum_valid_in = 1'b1; cyc();
    chk("ws_psum", sa(pe_psum_out), -2);
    chk("ws_pv", pe_psum_valid_out, 1);
    chk("model_ws_psum", e_psum, -2);
    clr(); pe_psum_in = 16'd10; pe_psum_valid_in = 1'b1; cyc();
    chk("ws_idle_psum", sa(pe_psum_out), 0);
    chk("ws_idle_pv", pe_psum_valid_out, 0);

    // Double buffer: load 5 and switch together, then later switch again
    clr(); pe_weight_in = 8'd5; pe_valid_w_in = 1'b1; pe_switch_in = 1'b1; pe_input_in = 8'd2; pe_valid_in = 1'b1; cyc();
    chk("db_same", sa(pe_psum_out), 6);
    clr(); pe_input_in = 8'd2; pe_valid_in = 1'b1; cyc();
    chk("db_after", sa(pe_psum_out), 6);
    chk("db_whold", sd(pe_weight_out), 5);
    clr(); pe_switch_in = 1'b1; cyc();
    clr(); pe_input_in = 8'd2; pe_valid_in = 1'b1; cyc();
    chk("db_next", sa(pe_psum_out), 10);

    // Switch to OS: this cycle's MAC is discarded and psum zeroed
    pe_mode_in = 1'b1;
    clr(); mac(1, 1); cyc();
    chk("mode_psum", sa(pe_psum_out), 0);
    chk("mode_pv", pe_psum_valid_out, 0);
    for (int i = 0; i < 4; i++) begin
      clr(); mac(os_a[i], os_b[i]); cyc();
    end
    clr(); pe_drain_in = 1'b1; cyc();
    chk("os_drain", sa(pe_psum_out), 15);
    chk("os_drain_v", pe_psum_valid_out, 1);
    chk("model_os_drain", e_psum, 15);
    clr(); cyc();
    clr(); pe_drain_in = 1'b1; cyc();
    chk("os_cleared", sa(pe_psum_out), 0);
    chk("os_cleared_v", pe_psum_valid_out, 1);
    clr(); cyc();
    clr(); pe_psum_in = 16'd1234; pe_psum_valid_in = 1'b1; cyc();
    chk("os_fwd", sa(pe_psum_out), 1234);

    // Drain with a same-cycle MAC, then MAC during drain and deferred mode change
    clr(); mac(5, 6); cyc();
    clr(); mac(2, 2); pe_drain_in = 1'b1; cyc();
    chk("drain_mac", sa(pe_psum_out), 34);
    pe_mode_in = 1'b0;
    clr(); mac(3, 3); pe_psum_in = 16'd77; pe_psum_valid_in = 1'b1; cyc();
    chk("drain_fwd", sa(pe_psum_out), 77);
    chk("drain_fwd_v", pe_psum_valid_out, 1);
    pe_mode_in = 1'b1;
    clr(); cyc();
    clr(); pe_drain_in = 1'b1; cyc();
    chk("drain_acc", sa(pe_psum_out), 9);
    clr(); cyc();

    // Collision
    clr(); mac(10, 10); cyc();
    clr(); pe_drain_in = 1'b1; pe_psum_in = 16'd999; pe_psum_valid_in = 1'b1; cyc();
    chk("coll_psum", sa(pe_psum_out), 100);
    chk("coll_err", pe_err_out, 1);
    clr(); cyc();
    chk("coll_sticky", pe_err_out, 1);
    clr(); cyc();

    // Overflow: 32766 + 16129
    for (int i = 0; i < 4; i++) begin
      clr(); mac(127, ov_b[i]); cyc();
    end
    clr(); pe_drain_in = 1'b1; cyc();
`ifdef PE_SATURATE_EN
    chk("ovf_psum", sa(pe_psum_out), 32767);
    chk("ovf_flag", pe_ovf_out, 1);
`else
    chk("ovf_psum", sa(pe_psum_out), -16641);
    chk("ovf_flag", pe_ovf_out, 0);
`endif
    clr(); cyc();

    // Reset mid-stream with acc = 500
    clr(); mac(20, 25); cyc();
    rst = 1'b1;
    clr();
    #1;
    chk("mrst_psum", sa(pe_psum_out), 0);
    chk("mrst_pv", pe_psum_valid_out, 0);
    chk("mrst_in", sd(pe_input_out), 0);
    chk("mrst_w", sd(pe_weight_out), 0);
    chk("mrst_err", pe_err_out, 0);
    chk("mrst_ovf", pe_ovf_out, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc();
    clr(); pe_drain_in = 1'b1; cyc();
    chk("mrst_drain", sa(pe_psum_out), 0);
    chk("mrst_drain_v", pe_psum_valid_out, 1);

    // Back to WS: active weight was cleared by reset
    clr(); pe_mode_in = 1'b0; cyc();
    cyc();
    clr(); pe_input_in = 8'd5; pe_valid_in = 1'b1; pe_psum_in = 16'd7; pe_psum_valid_in = 1'b1; cyc();
    chk("ws_after_rst", sa(pe_psum_out), 7);
    clr(); cyc();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
